mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-side stage that directly feeds the MDR's memory-data input (Mdatain) and consumes MAR address and MDR output for stores.
- Holds the word-addressed RAM array.
- Services one Read or Write request at a time through a wait-state FSM.
- Signals completion to the control unit with a one-cycle mem_done pulse.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, word address width; the array holds 2^ADDR_W words.
- WAIT_STATES, 2, extra access cycles; legal range 0..15.
- PROT_LIMIT, 9'h040, first writable address; used only when MEM_WPROT_EN is defined.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- MAR_addr  in  ADDR_W  access address from MAR.
- wdata  in  DATA_W  store data from MDR Q.
- Read  in  1  read request, level-sampled in IDLE.
- Write  in  1  write request, level-sampled in IDLE.
- Mdatain  out  DATA_W  read data to the MDR mux input; registered.
- mem_busy  out  1  high in WAIT and ACCESS.
- mem_done  out  1  one-cycle completion pulse in DONE.
- mem_fault  out  1  protected-write flag; constant 0 without the macro.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE, wait counter = 0.
  - Mdatain = 0, mem_busy = 0, mem_done = 0, mem_fault = 0.
  - RAM contents are not cleared.
- FSM states are IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On an edge with Read=1 or Write=1: latch MAR_addr, latch wdata, latch op.
  - Next state is WAIT with counter = WAIT_STATES, or ACCESS directly if WAIT_STATES = 0.
  - If Read=1 and Write=1 together: Read wins and no write occurs.
- WAIT: counter decrements each edge; on an edge where counter = 1, go to ACCESS.
- ACCESS (one edge):
  - Read: Mdatain <= mem[addr_latched].
  - Write: mem[addr_latched] <= wdata_latched.
  - Then go to DONE.
- DONE: mem_done = 1 for exactly one cycle; next edge returns to IDLE.
- Latency: request sampled at edge E0; mem_done is high in the cycle following edge E0+WAIT_STATES+1.
  - WAIT_STATES=2 gives mem_done after the 3rd edge.
  - WAIT_STATES=0 gives mem_done after the 1st edge.
- Mdatain holds the last completed read value. Writes, idle cycles and ignored requests leave it unchanged.
- Input changes while not in IDLE:
  - Read/Write outside IDLE are ignored; there is no queueing.
  - MAR_addr/wdata changes after latching are ignored.
- Strobe still high on return to IDLE: a new access starts. The control unit must drop the strobe on mem_done.
- Reset mid-operation:
  - The access is aborted.
  - A write is not committed unless the ACCESS edge has already occurred.
  - mem_done is not generated for the aborted access.
- Address wrap: none. ADDR_W covers the whole array, so every address is valid.

Optional Feature:
- Macro: MEM_WPROT_EN.
- Defined:
  - A write with addr_latched < PROT_LIMIT is not committed in ACCESS.
  - The handshake still completes normally.
  - mem_fault = 1 during that DONE cycle only; 0 otherwise.
  - Reads are never protected.
- Undefined:
  - All writes commit.
  - mem_fault is tied to 0.
  - PROT_LIMIT is unused.

Test Plan:
- Reset during WAIT of a write to 0x080 (data 0xDEADBEEF):
  - All outputs are 0 immediately.
  - A later read of 0x080 does not return 0xDEADBEEF.
- WAIT_STATES=2: write 0x12345678 to 0x0A5, then read 0x0A5.
  - Each mem_done goes high exactly 3 edges after the request.
  - Mdatain = 0x12345678; mem_busy high for 3 cycles.
- Read and Write asserted together at 0x100 (mem holds 0x11111111, wdata 0x22222222):
  - Read is performed and Mdatain = 0x11111111.
  - A follow-up read still returns 0x11111111.
- Change MAR_addr from 0x010 to 0x020 and toggle Read during WAIT:
  - The access completes on 0x010 only.
  - No second mem_done occurs while Read stays low after DONE.
- WAIT_STATES=0: read 0x001 returns data with mem_done after the 1st edge; a Write between reads leaves Mdatain unchanged.
- MEM_WPROT_EN defined: write 0xCAFEF00D to 0x03F.
  - mem_done=1 and mem_fault=1 for one cycle.
  - A read of 0x03F returns its old value.
  - A write to 0x040 commits with mem_fault=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bus between the control unit (master) and the memory access stage (slave):
// MAR address, MDR store data, Read/Write strobes, read data and status.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] MAR_addr;
    logic [DATA_W-1:0] wdata;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_fault;

    modport master (
        output MAR_addr, wdata, Read, Write,
        input  Mdatain, mem_busy, mem_done, mem_fault
    );

    modport slave (
        input  MAR_addr, wdata, Read, Write,
        output Mdatain, mem_busy, mem_done, mem_fault
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access stage: word-addressed RAM behind a wait-state FSM
// (IDLE -> WAIT -> ACCESS -> DONE). One Read or Write is serviced at a time;
// completion is a one-cycle mem_done pulse. Mdatain holds the last read word.
// Optional build macro MEM_WPROT_EN: writes below PROT_LIMIT are dropped and
// flagged with mem_fault during the DONE cycle.
module mem_access_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 9,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] PROT_LIMIT  = 9'h040
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_rd_q, op_rd_d;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              mem_we_s;
    logic              rd_en_s;
    logic              wr_blocked_s;

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

`ifdef MEM_WPROT_EN
    assign wr_blocked_s = (addr_q < PROT_LIMIT);
`else
    logic unused_prot_s;
    assign wr_blocked_s  = 1'b0;
    assign unused_prot_s = ^PROT_LIMIT;
`endif

    // Next-state, request latching, RAM strobes and next output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_rd_d  = op_rd_q;
        mem_we_s = 1'b0;
        rd_en_s  = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Read || bus.Write) begin
                    addr_d  = bus.MAR_addr;
                    wdata_d = bus.wdata;
                    // Read has priority when both strobes are high.
                    op_rd_d = bus.Read;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= also recovers from a corrupted zero count.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                if (op_rd_q) begin
                    rd_en_s = 1'b1;
                end else begin
                    mem_we_s = !wr_blocked_s;
                    fault_d  = wr_blocked_s;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d == ST_WAIT) || (state_d == ST_ACCESS);
        done_d = (state_d == ST_DONE);
    end

    // FSM state, latched request and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_rd_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_rd_q <= op_rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Read data register: updated only by a completed read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en_s) begin
            rdata_q <= mem_q[addr_q];
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.Mdatain   = rdata_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_done  = done_q;
    assign bus.mem_fault = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with WAIT_STATES=2 and one
// with WAIT_STATES=0, each on its own bus interface.
module tb_mem_access_ctrl;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(9)) if2 ();
    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(9)) if0 ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2), .PROT_LIMIT(9'h040))
        u_dut2 (.clock(clock), .reset(reset), .bus(if2.slave));

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0), .PROT_LIMIT(9'h040))
        u_dut0 (.clock(clock), .reset(reset), .bus(if0.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel) begin
            if0.Read = rd; if0.Write = wr; if0.MAR_addr = a; if0.wdata = d;
        end else begin
            if2.Read = rd; if2.Write = wr; if2.MAR_addr = a; if2.wdata = d;
        end
    endtask

    function automatic logic [31:0] rdata(input bit sel);
        return sel ? if0.Mdatain : if2.Mdatain;
    endfunction

    // Issues one request (sampled at edge E0) and watches 24 further edges.
    // lat = edges after E0 until mem_done, 0 if never seen.
    task automatic run_op(input bit sel, input bit rd, input bit wr,
                          input logic [8:0] a, input logic [31:0] d, input bit disturb,
                          output int lat, output int busy_n, output int fault_n,
                          output int late_done);
        logic b, dn, f;
        lat = 0; busy_n = 0; fault_n = 0; late_done = 0;
        @(negedge clock);
        drive(sel, rd, wr, a, d);
        @(posedge clock); #1;
        if (disturb) drive(sel, 1'b1, 1'b0, 9'h020, 32'h0000_0000);
        else         drive(sel, 1'b0, 1'b0, a, d);
        for (int k = 0; k < 25; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            if (k == 1) drive(sel, 1'b0, 1'b0, a, d);
            b  = sel ? if0.mem_busy  : if2.mem_busy;
            dn = sel ? if0.mem_done  : if2.mem_done;
            f  = sel ? if0.mem_fault : if2.mem_fault;
            if (b) busy_n++;
            if (f) fault_n++;
            if (dn) begin
                if (lat == 0) lat = k;
                else          late_done++;
            end
        end
    endtask

    int lat, busy_n, fault_n, late_done;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
        #12;
        check_eq("rst_mdatain2", if2.Mdatain, 32'h0);
        check_eq("rst_busy2",    {31'd0, if2.mem_busy},  32'd0);
        check_eq("rst_done2",    {31'd0, if2.mem_done},  32'd0);
        check_eq("rst_fault2",   {31'd0, if2.mem_fault}, 32'd0);
        check_eq("rst_mdatain0", if0.Mdatain, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Write then read 0x0A5 with two wait states.
        run_op(1'b0, 1'b0, 1'b1, 9'h0A5, 32'h1234_5678, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("wr_latency",   lat,    32'd3);
        check_eq("wr_busy_cyc",  busy_n, 32'd3);
        check_eq("wr_done_once", late_done, 32'd0);
        check_eq("wr_keeps_mdatain", rdata(1'b0), 32'h0);
        run_op(1'b0, 1'b1, 1'b0, 9'h0A5, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("rd_latency",   lat,    32'd3);
        check_eq("rd_busy_cyc",  busy_n, 32'd3);
        check_eq("rd_data_0a5",  rdata(1'b0), 32'h1234_5678);

        // Reset during WAIT of a write to 0x080 aborts it.
        run_op(1'b0, 1'b0, 1'b1, 9'h080, 32'h0BAD_C0DE, 1'b0, lat, busy_n, fault_n, late_done);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 9'h080, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 9'h080, 32'hDEAD_BEEF);
        check_eq("abort_busy_pre", {31'd0, if2.mem_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_mdatain", if2.Mdatain, 32'h0);
        check_eq("abort_busy",    {31'd0, if2.mem_busy}, 32'd0);
        check_eq("abort_done",    {31'd0, if2.mem_done}, 32'd0);
        check_eq("abort_fault",   {31'd0, if2.mem_fault}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(1'b0, 1'b1, 1'b0, 9'h080, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("abort_rd_lat",  lat, 32'd3);
        check_eq("abort_no_commit", rdata(1'b0), 32'h0BAD_C0DE);

        // Read and Write together: Read wins, no write.
        run_op(1'b0, 1'b0, 1'b1, 9'h100, 32'h1111_1111, 1'b0, lat, busy_n, fault_n, late_done);
        run_op(1'b0, 1'b1, 1'b1, 9'h100, 32'h2222_2222, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("rw_latency", lat, 32'd3);
        check_eq("rw_read_wins", rdata(1'b0), 32'h1111_1111);
        run_op(1'b0, 1'b1, 1'b0, 9'h0A5, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        run_op(1'b0, 1'b1, 1'b0, 9'h100, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("rw_no_write", rdata(1'b0), 32'h1111_1111);

        // Address change and Read toggle during WAIT are ignored.
        run_op(1'b0, 1'b0, 1'b1, 9'h010, 32'hAAAA_0010, 1'b0, lat, busy_n, fault_n, late_done);
        run_op(1'b0, 1'b0, 1'b1, 9'h020, 32'hBBBB_0020, 1'b0, lat, busy_n, fault_n, late_done);
        run_op(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1, lat, busy_n, fault_n, late_done);
        check_eq("dist_latency", lat, 32'd3);
        check_eq("dist_addr_kept", rdata(1'b0), 32'hAAAA_0010);
        check_eq("dist_no_2nd_done", late_done, 32'd0);
        check_eq("dist_busy_cyc", busy_n, 32'd3);

        // Zero wait states.
        run_op(1'b1, 1'b0, 1'b1, 9'h001, 32'h5A5A_0001, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("ws0_wr_latency", lat, 32'd1);
        run_op(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("ws0_rd_latency", lat, 32'd1);
        check_eq("ws0_rd_busy",    busy_n, 32'd1);
        check_eq("ws0_rd_data",    rdata(1'b1), 32'h5A5A_0001);
        run_op(1'b1, 1'b0, 1'b1, 9'h002, 32'h0000_0077, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("ws0_wr_keeps",   rdata(1'b1), 32'h5A5A_0001);
        run_op(1'b1, 1'b1, 1'b0, 9'h002, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("ws0_rd2_data",   rdata(1'b1), 32'h0000_0077);
        check_eq("ws0_done_once",  late_done, 32'd0);

`ifdef MEM_WPROT_EN
        run_op(1'b0, 1'b0, 1'b1, 9'h03F, 32'hCAFE_F00D, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("prot_latency", lat, 32'd3);
        check_eq("prot_fault_cyc", fault_n, 32'd1);
        run_op(1'b0, 1'b1, 1'b0, 9'h03F, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("prot_not_written", {31'd0, (rdata(1'b0) != 32'hCAFE_F00D)}, 32'd1);
        check_eq("prot_rd_fault", fault_n, 32'd0);
        run_op(1'b0, 1'b0, 1'b1, 9'h040, 32'hCAFE_0040, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("prot_lim_fault", fault_n, 32'd0);
        run_op(1'b0, 1'b1, 1'b0, 9'h040, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("prot_lim_commit", rdata(1'b0), 32'hCAFE_0040);
`else
        run_op(1'b0, 1'b0, 1'b1, 9'h03F, 32'hCAFE_F00D, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("noprot_latency", lat, 32'd3);
        check_eq("noprot_fault", fault_n, 32'd0);
        run_op(1'b0, 1'b1, 1'b0, 9'h03F, 32'h0, 1'b0, lat, busy_n, fault_n, late_done);
        check_eq("noprot_commit", rdata(1'b0), 32'hCAFE_F00D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
